// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin output mux.
// Defaults for channel count/width and transfer counter width.
package rr_mux_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int XFER_W     = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from i_last+1 with wrap; first requester wins.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CHW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CHW-1:0]    i_last,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CHW-1:0]    o_idx,
    output logic              o_any
);

    logic           w_found;
    int             w_sum;
    logic [CHW-1:0] w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_c     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_sum = (int'(i_last) + k) % NUM_CH;
            w_c   = CHW'(w_sum);
            if (!w_found && i_req[w_c]) begin
                o_grant[w_c] = 1'b1;
                o_idx        = w_c;
                w_found      = 1'b1;
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/rr_mux_n.sv
// N-channel round-robin mux with a single registered output stage.
// Define RRMUX_COUNT_EN to add the xfer_count output-transfer counter.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CHW    = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CHW-1:0]          out_ch,
    input  logic                    out_ready
`ifdef RRMUX_COUNT_EN
    ,
    output logic [XFER_W-1:0]       xfer_count
`endif
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CHW-1:0]   r_ch;
    logic [CHW-1:0]   r_last;

    logic              w_load;
    logic [NUM_CH-1:0] w_grant;
    logic [CHW-1:0]    w_idx;
    logic              w_any;
    logic [WIDTH-1:0]  w_ch_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (in_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Register is free when empty or being drained this cycle.
    assign w_load   = !r_valid || out_ready;
    assign in_ready = (w_load && !reset) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= CHW'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_ch_data[w_idx];
                r_ch    <= w_idx;
                r_last  <= w_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef RRMUX_COUNT_EN
    logic [XFER_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_valid && out_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign xfer_count = r_cnt;
`endif

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n against a behavioural model.
// Counter checks are compiled in when RRMUX_COUNT_EN is defined.
module tb_rr_mux_n;

    localparam int NC = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] in_valid;
    logic [NC*W-1:0] in_data;
    logic [NC-1:0] in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_ready;
`ifdef RRMUX_COUNT_EN
    logic [15:0]   xfer_count;
`endif

    rr_mux_n #(.WIDTH(W), .NUM_CH(NC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef RRMUX_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the output register should hold.
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_ch;
    int          m_last;
    logic [15:0] m_cnt;

    function automatic int pick(int last, logic [NC-1:0] v);
        for (int k = 1; k <= NC; k++) begin
            if (v[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    function automatic logic [NC-1:0] model_ready();
        int w;
        if (reset) return '0;
        if (m_valid && !out_ready) return '0;
        w = pick(m_last, in_valid);
        if (w < 0) return '0;
        return NC'(1) << w;
    endfunction

    task automatic model_edge();
        int w;
        if (reset) begin
            m_valid = 0; m_data = '0; m_ch = 0; m_last = NC - 1; m_cnt = '0;
        end else begin
            if (m_valid && out_ready) m_cnt = m_cnt + 16'd1;
            if (!m_valid || out_ready) begin
                w = pick(m_last, in_valid);
                if (w >= 0) begin
                    m_valid = 1; m_data = in_data[w*W +: W];
                    m_ch = w; m_last = w;
                end else begin
                    m_valid = 0;
                end
            end
        end
    endtask

    task automatic drive(bit rst, logic [NC-1:0] v, logic [NC*W-1:0] d, bit ordy);
        @(negedge clk);
        reset = rst; in_valid = v; in_data = d; out_ready = ordy;
        #1;
    endtask

    function automatic logic [NC*W-1:0] ramp(logic [W-1:0] base);
        logic [NC*W-1:0] d;
        for (int i = 0; i < NC; i++) d[i*W +: W] = base + W'(i);
        return d;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1, 4'b1111, ramp(8'h40), 1);
            n_checks++;
            if (in_ready !== 4'b0000)
                $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
            else n_pass++;
            @(posedge clk); model_edge(); #1;
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0)
                $display("FAIL reset_out got v=%b d=%h ch=%0d exp 0/00/0",
                         out_valid, out_data, out_ch);
            else n_pass++;
`ifdef RRMUX_COUNT_EN
            n_checks++;
            if (xfer_count !== 16'd0)
                $display("FAIL reset_count got=%0d exp=0", xfer_count);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_single();
        logic [NC*W-1:0] d;
        d = ramp(8'h00);
        d[2*W +: W] = 8'hA5;
        drive(0, 4'b0100, d, 1);
        n_checks++;
        if (in_ready !== 4'b0100)
            $display("FAIL single_ready got=%b exp=0100", in_ready);
        else n_pass++;
        @(posedge clk); model_edge(); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2)
            $display("FAIL single_out got v=%b d=%h ch=%0d exp 1/a5/2",
                     out_valid, out_data, out_ch);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_seq [6];
        exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        drive(1, 4'b0000, '0, 1);
        @(posedge clk); model_edge();
        for (int c = 0; c < 6; c++) begin
            drive(0, 4'b1111, ramp(8'h10), 1);
            @(posedge clk); model_edge(); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[c])
                $display("FAIL rr_seq[%0d] got v=%b d=%h exp 1/%h",
                         c, out_valid, out_data, exp_seq[c]);
            else n_pass++;
        end
`ifdef RRMUX_COUNT_EN
        n_checks++;
        if (xfer_count !== 16'd5)
            $display("FAIL rr_count got=%0d exp=5", xfer_count);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        drive(1, 4'b0000, '0, 1);
        @(posedge clk); model_edge();
        for (int c = 0; c < 2; c++) begin
            drive(0, 4'b1111, ramp(8'h10), 1);
            @(posedge clk); model_edge();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b1111, ramp(8'h10), 0);
            n_checks++;
            if (in_ready !== 4'b0000)
                $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready);
            else n_pass++;
            @(posedge clk); model_edge(); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11)
                $display("FAIL bp_hold[%0d] got v=%b d=%h exp 1/11",
                         c, out_valid, out_data);
            else n_pass++;
        end
        drive(0, 4'b1111, ramp(8'h10), 1);
        n_checks++;
        if (in_ready !== 4'b0100)
            $display("FAIL bp_release_ready got=%b exp=0100", in_ready);
        else n_pass++;
        @(posedge clk); model_edge(); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h12 || out_ch !== 2'd2)
            $display("FAIL bp_release got v=%b d=%h ch=%0d exp 1/12/2",
                     out_valid, out_data, out_ch);
        else n_pass++;
    endtask

    task automatic test_bubble();
        logic [NC*W-1:0] d;
        drive(1, 4'b0000, '0, 1);
        @(posedge clk); model_edge();
        d = '0;
        d[W-1:0] = 8'h5A;
        drive(0, 4'b0001, d, 1);
        @(posedge clk); model_edge();
        drive(0, 4'b0000, '0, 1);
        n_checks++;
        if (in_ready !== 4'b0000)
            $display("FAIL bubble_ready got=%b exp=0000", in_ready);
        else n_pass++;
        @(posedge clk); model_edge(); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A)
            $display("FAIL bubble_out got v=%b d=%h exp 0/5a",
                     out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NC*W-1:0] d;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NC; i++) d[i*W +: W] = W'($urandom);
            drive(($urandom_range(0, 39) == 0), NC'($urandom),
                  d, ($urandom_range(0, 3) != 0));
            n_checks++;
            if (in_ready !== model_ready())
                $display("FAIL rand_ready[%0d] got=%b exp=%b",
                         c, in_ready, model_ready());
            else n_pass++;
            @(posedge clk); model_edge(); #1;
            n_checks++;
            if (out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_ch !== 2'(m_ch))))
                $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp %b/%h/%0d",
                         c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            else n_pass++;
`ifdef RRMUX_COUNT_EN
            n_checks++;
            if (xfer_count !== m_cnt)
                $display("FAIL rand_count[%0d] got=%0d exp=%0d",
                         c, xfer_count, m_cnt);
            else n_pass++;
`endif
        end
    endtask

`ifdef RRMUX_COUNT_EN
    task automatic test_count_wrap();
        drive(1, 4'b0000, '0, 1);
        @(posedge clk); model_edge();
        drive(0, 4'b1111, ramp(8'h20), 1);
        for (int c = 0; c < 65537; c++) begin
            @(posedge clk); model_edge();
        end
        #1;
        n_checks++;
        if (xfer_count !== 16'd0 || xfer_count !== m_cnt)
            $display("FAIL count_wrap got=%0d exp=0", xfer_count);
        else n_pass++;
    endtask
`endif

    initial begin
        reset = 1; in_valid = '0; in_data = '0; out_ready = 0;
        m_valid = 0; m_data = '0; m_ch = 0; m_last = NC - 1; m_cnt = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bubble();
        test_random();
`ifdef RRMUX_COUNT_EN
        test_count_wrap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
